// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, P-times oversampled bit timing (P = 8/16/32), optional parity.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (bit value = majority of three mid-bit samples).
module uart_rx #(
  parameter int Data_Width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [Data_Width-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err
);
  localparam int BitW = $clog2(Data_Width + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d, p_q, p_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  pe_q, pe_d, pt_q, pt_d;
  logic [Data_Width-1:0] sh_q, sh_d, pdata_q, pdata_d;
  logic                  par_rx_q, par_rx_d, stop_q, stop_d;
  logic                  dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
  logic                  arm_q, arm_d;
  logic                  sync1_q, rx_s_q, smp_b_q;
  logic [1:0]            vld_q;
  logic [5:0]            half;
  logic                  end_bit, at_dec, bit_val;

  assign half    = p_q >> 1;
  assign end_bit = (cnt_q == p_q - 6'd1);
  // Bit decisions are taken one count after mid-bit so both sampling modes share the same timing.
  assign at_dec  = (cnt_q == half + 6'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      vld_q   <= '0;
      smp_b_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      if (cnt_q == half) smp_b_q <= rx_s_q;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic smp_a_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      smp_a_q <= 1'b1;
    else if (cnt_q == half - 6'd1) smp_a_q <= rx_s_q;
  end

  assign bit_val = (smp_a_q & smp_b_q) | (smp_a_q & rx_s_q) | (smp_b_q & rx_s_q);
`else
  assign bit_val = smp_b_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 6'd1;
    bit_d    = bit_q;
    p_d      = p_q;
    pe_d     = pe_q;
    pt_d     = pt_q;
    sh_d     = sh_q;
    par_rx_d = par_rx_q;
    stop_d   = stop_q;
    pdata_d  = pdata_q;
    dv_d     = 1'b0;
    perr_d   = 1'b0;
    serr_d   = 1'b0;
    // Start detection stays disarmed until the synchronizer has shown a real idle-high line.
    arm_d    = arm_q | (vld_q[1] & rx_s_q);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (arm_q && !rx_s_q) begin
          state_d = START;
          p_d     = (prescale == 6'd8 || prescale == 6'd16 || prescale == 6'd32) ? prescale : 6'd8;
          pe_d    = par_en;
          pt_d    = par_typ;
        end
      end
      START: begin
        if (at_dec && bit_val) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (end_bit) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (at_dec) begin
          sh_d  = {bit_val, sh_q[Data_Width-1:1]};
          bit_d = bit_q + BitW'(1);
        end
        if (end_bit) begin
          cnt_d = '0;
          if (bit_q == BitW'(Data_Width)) state_d = pe_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_dec) par_rx_d = bit_val;
        if (end_bit) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (at_dec) stop_d = bit_val;
        if (end_bit) begin
          cnt_d   = '0;
          state_d = IDLE;
          perr_d  = pe_q & (par_rx_q != ((^sh_q) ^ pt_q));
          serr_d  = ~stop_q;
          dv_d    = ~(perr_d | serr_d);
          if (dv_d) pdata_d = sh_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      p_q      <= 6'd8;
      pe_q     <= 1'b0;
      pt_q     <= 1'b0;
      sh_q     <= '0;
      par_rx_q <= 1'b0;
      stop_q   <= 1'b0;
      pdata_q  <= '0;
      dv_q     <= 1'b0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      p_q      <= p_d;
      pe_q     <= pe_d;
      pt_q     <= pt_d;
      sh_q     <= sh_d;
      par_rx_q <= par_rx_d;
      stop_q   <= stop_d;
      pdata_q  <= pdata_d;
      dv_q     <= dv_d;
      perr_q   <= perr_d;
      serr_q   <= serr_d;
      arm_q    <= arm_d;
    end
  end

  assign p_data     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = perr_q;
  assign stop_err   = serr_q;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter Data_Width, default 8, giving the frame data bits.
REQ-002 The block SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_in  input  1  serial line, idle high.
REQ-005 The block SHALL have port prescale  input  6  oversampling ratio, clocks per bit; legal values 8, 16 and 32.
REQ-006 The block SHALL have port par_en  input  1  1 means a parity bit follows the data.
REQ-007 The block SHALL have port par_typ  input  1  0 means even parity, 1 means odd parity.
REQ-008 The block SHALL have port p_data  output  Data_Width  received word.
REQ-009 The block SHALL have port data_valid  output  1  one-cycle pulse, p_data is good.
REQ-010 The block SHALL have port par_err  output  1  one-cycle pulse, parity mismatch.
REQ-011 The block SHALL have port stop_err  output  1  one-cycle pulse, stop bit sampled 0.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer; all timing below refers to the synchronized signal (rx_s).
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 FSM transitions SHALL be:
- IDLE->START when rx_s=0.
- START->DATA at end of bit; START->IDLE if the start sample is 1 (glitch reject, no outputs).
- DATA->PARITY after Data_Width bits if par_en=1, else DATA->STOP.
- PARITY->STOP at end of bit.
- STOP->IDLE at end of bit.
REQ-015 An edge counter SHALL run 0..P-1 per bit and a bit counter SHALL count data bits; both clear on entering START.
REQ-016 P SHALL be prescale latched on IDLE->START; any illegal value SHALL latch as 8.
REQ-017 par_en and par_typ SHALL also be latched on IDLE->START; changes mid-frame SHALL have no effect.
REQ-018 The bit value SHALL be sampled when edge count = P/2.
REQ-019 Data SHALL be received LSB first into a shift register.
REQ-020 The expected parity bit SHALL be the XOR of the data bits for even parity, or its inverse for odd parity.
REQ-021 In the cycle after edge count P-1 of STOP, the block SHALL pulse exactly one of:
- data_valid, with p_data updated, when there is no error.
- par_err and/or stop_err otherwise, with p_data unchanged.
REQ-022 p_data SHALL hold its value between valid frames.
REQ-023 A frame starting immediately after STOP (rx_s=0 in the first IDLE cycle) SHALL be accepted with no lost bit time.
REQ-024 With P=8 and par_en=1, a frame SHALL take 11×8 = 88 clocks from start-bit detect to the output pulse, plus 1 cycle.

Reset
REQ-025 When rst=0, the block SHALL asynchronously force:
- FSM to IDLE;
- all counters, p_data, data_valid, par_err and stop_err to 0;
- synchronizer flops to 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-027 After reset release, the block SHALL require rx_s=1 before it can detect a start bit, so a line held low is not taken as a start.

Configuration
REQ-028 With macro UART_RX_MAJORITY_VOTE_EN defined, each bit SHALL be the majority of three samples at edge counts P/2-1, P/2 and P/2+1.
REQ-029 Without UART_RX_MAJORITY_VOTE_EN, each bit SHALL be the single sample of REQ-018.
REQ-030 Frame timing and output latency SHALL be identical with and without UART_RX_MAJORITY_VOTE_EN.

Verification
REQ-031 Even-parity frame: P=8, par_en=1, par_typ=0, send 0xA5 with parity bit 0 -> data_valid pulses once, 89 clocks after the start edge, with p_data=0xA5 and no error pulses.
REQ-032 Odd-parity mismatch: P=16, par_en=1, par_typ=1, send 0x3C with parity bit 0 -> par_err pulses once, data_valid stays 0, p_data keeps its old value.
REQ-033 Stop and parity disabled: P=32, par_en=0, send 0xFF then 0x00 back-to-back -> two data_valid pulses; then a frame with stop=0 -> stop_err pulses.
REQ-034 Glitch and reset:
- A 3-clock low pulse on rx_in at P=8 -> no output, FSM back in IDLE.
- rst=0 during DATA -> all outputs 0 immediately, and the next clean frame is received correctly.
REQ-035 Majority vote: with UART_RX_MAJORITY_VOTE_EN defined, a 1-clock inversion at edge count P/2 of data bit 3 -> p_data is correct.
REQ-036 Without UART_RX_MAJORITY_VOTE_EN, the same 1-clock inversion at edge count P/2 of data bit 3 -> bit 3 of p_data is flipped.
